// File: rtl/onchip_mem_arbiter.sv
// Two-master round-robin arbiter in front of a single-port synchronous RAM.
// Grants are combinational. Read responses are returned one cycle after acceptance.
module onchip_mem_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int BE_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reset_req,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
);

  logic req0, req1, block, gnt0, gnt1;
  logic last_grant_q, last_grant_d;
  logic rd_pend_q, rd_pend_d;
  logic rd_owner_q, rd_owner_d;

  // last_grant_q=1 means m1 was served last, so m0 wins the next contention.
  always_comb begin
    req0  = m0_read | m0_write;
    req1  = m1_read | m1_write;
    block = reset | reset_req;
    gnt0  = ~block & req0 & (~req1 | last_grant_q);
    gnt1  = ~block & req1 & (~req0 | ~last_grant_q);

    last_grant_d = last_grant_q;
    if (gnt1)      last_grant_d = 1'b1;
    else if (gnt0) last_grant_d = 1'b0;

    // A read with write also set is a write and gets no response.
    rd_pend_d  = (gnt0 & m0_read & ~m0_write) | (gnt1 & m1_read & ~m1_write);
    rd_owner_d = rd_pend_d ? gnt1 : rd_owner_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= 1'b1;
      rd_pend_q    <= 1'b0;
      rd_owner_q   <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      rd_pend_q    <= rd_pend_d;
      rd_owner_q   <= rd_owner_d;
    end
  end

  always_comb begin
    mem_address    = '0;
    mem_byteenable = '0;
    mem_writedata  = '0;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    if (gnt0) begin
      mem_address    = m0_address;
      mem_byteenable = m0_byteenable;
      mem_writedata  = m0_writedata;
      mem_chipselect = 1'b1;
      mem_write      = m0_write;
    end else if (gnt1) begin
      mem_address    = m1_address;
      mem_byteenable = m1_byteenable;
      mem_writedata  = m1_writedata;
      mem_chipselect = 1'b1;
      mem_write      = m1_write;
    end
  end

  assign mem_clken      = ~reset_req;
  assign m0_waitrequest = req0 & ~gnt0;
  assign m1_waitrequest = req1 & ~gnt1;
  assign m0_readdata    = mem_readdata;
  assign m1_readdata    = mem_readdata;

  // A response pending when reset arrives is dropped, not delivered.
  assign m0_readdatavalid = rd_pend_q & ~reset & ~rd_owner_q;
  assign m1_readdatavalid = rd_pend_q & ~reset &  rd_owner_q;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Bench for onchip_mem_arbiter: RAM model, shadow memory and a read-response scoreboard.
module tb_onchip_mem_arbiter;
  logic        clk = 0, reset = 1, reset_req = 0;
  logic [11:0] m0_address = 0, m1_address = 0;
  logic [3:0]  m0_byteenable = 0, m1_byteenable = 0;
  logic        m0_read = 0, m0_write = 0, m1_read = 0, m1_write = 0;
  logic [31:0] m0_writedata = 0, m1_writedata = 0;
  logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic [31:0] m0_readdata, m1_readdata;
  logic [11:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [31:0] mem_writedata, mem_readdata;

  int errors = 0, checks = 0, cyc = 0;

  typedef struct { logic owner; logic [31:0] data; int cyc; } exp_t;
  exp_t sb[$];
  exp_t e;
  logic [31:0] ref_mem [4096];
  logic [31:0] ram [4096];
  logic [11:0] ram_addr_q = 0;

  onchip_mem_arbiter dut (
    .clk(clk), .reset(reset), .reset_req(reset_req),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM: registered address, unregistered q, everything frozen while clken is low.
  always @(posedge clk) begin
    if (mem_clken) begin
      ram_addr_q <= mem_address;
      if (mem_chipselect && mem_write)
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
    end
  end
  assign mem_readdata = ram[ram_addr_q];

  // Response monitor: every readdatavalid must match the oldest expected read.
  always @(negedge clk) begin
    if (m0_readdatavalid && m1_readdatavalid) begin
      checks++; errors++; $display("FAIL both_valid m0v=1 m1v=1 required one-hot");
    end else if (m0_readdatavalid || m1_readdatavalid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++; $display("FAIL unexpected_valid cyc=%0d m0v=%0b m1v=%0b", cyc, m0_readdatavalid, m1_readdatavalid);
      end else begin
        e = sb.pop_front();
        if (m1_readdatavalid !== e.owner || m0_readdata !== e.data || cyc != e.cyc) begin
          errors++;
          $display("FAIL rd_resp got owner=%0b data=%h cyc=%0d required owner=%0b data=%h cyc=%0d",
                   m1_readdatavalid, m0_readdata, cyc, e.owner, e.data, e.cyc);
        end
      end
    end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      checks++; errors++;
      $display("FAIL missing_valid cyc=%0d required owner=%0b data=%h", cyc, e.owner, e.data);
    end
  end

  task automatic step(); @(posedge clk); #1; endtask

  task automatic drv0(input logic rd, input logic wr, input logic [11:0] a, input logic [3:0] be, input logic [31:0] d);
    m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = d;
  endtask

  task automatic drv1(input logic rd, input logic wr, input logic [11:0] a, input logic [3:0] be, input logic [31:0] d);
    m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = d;
  endtask

  task automatic idle(); drv0(0, 0, 0, 0, 0); drv1(0, 0, 0, 0, 0); endtask

  function automatic void shadow_wr(input logic [11:0] a, input logic [3:0] be, input logic [31:0] d);
    for (int b = 0; b < 4; b++) if (be[b]) ref_mem[a][b*8 +: 8] = d[b*8 +: 8];
  endfunction

  function automatic void expect_rd(input logic owner, input logic [31:0] d);
    exp_t x; x.owner = owner; x.data = d; x.cyc = cyc + 1; sb.push_back(x);
  endfunction

  task automatic test_reset();
    drv0(1, 0, 12'h005, 4'hF, 0); drv1(0, 1, 12'h006, 4'hF, 32'h99);
    #2;
    checks++; if ({m0_waitrequest, m1_waitrequest} !== 2'b11) begin errors++; $display("FAIL rst_wait got=%b required=11", {m0_waitrequest, m1_waitrequest}); end
    checks++; if ({mem_chipselect, mem_write} !== 2'b00) begin errors++; $display("FAIL rst_cs_we got=%b required=00", {mem_chipselect, mem_write}); end
    checks++; if (mem_clken !== 1'b1) begin errors++; $display("FAIL rst_clken got=%b required=1", mem_clken); end
    step(); step();
    checks++; if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00) begin errors++; $display("FAIL rst_valid got=%b required=00", {m0_readdatavalid, m1_readdatavalid}); end
    idle(); reset = 0;
    #1;
    checks++; if ({mem_chipselect, mem_address} !== 13'h0) begin errors++; $display("FAIL idle_mux got cs=%b addr=%h required 0/000", mem_chipselect, mem_address); end
  endtask

  task automatic test_write_read();
    step(); drv0(0, 1, 12'h010, 4'hF, 32'hDEADBEEF); #1;
    checks++; if (m0_waitrequest !== 1'b0) begin errors++; $display("FAIL wr_wait0 got=%b required=0", m0_waitrequest); end
    checks++; if ({mem_chipselect, mem_write, mem_address} !== {2'b11, 12'h010}) begin errors++; $display("FAIL wr_mux got cs=%b we=%b addr=%h required 1/1/010", mem_chipselect, mem_write, mem_address); end
    shadow_wr(12'h010, 4'hF, 32'hDEADBEEF);
    step(); drv0(1, 0, 12'h010, 4'hF, 0); #1;
    checks++; if (m0_waitrequest !== 1'b0) begin errors++; $display("FAIL rd_wait0 got=%b required=0", m0_waitrequest); end
    expect_rd(0, 32'hDEADBEEF);
    step(); idle(); #1;
    checks++; if ({m0_readdatavalid, m1_readdatavalid} !== 2'b10) begin errors++; $display("FAIL rd_latency got=%b required=10", {m0_readdatavalid, m1_readdatavalid}); end
    step(); #1;
    checks++; if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00) begin errors++; $display("FAIL rd_single got=%b required=00", {m0_readdatavalid, m1_readdatavalid}); end
  endtask

  task automatic test_byte_lanes();
    step(); drv0(0, 1, 12'h020, 4'hF, 32'h11223344); shadow_wr(12'h020, 4'hF, 32'h11223344);
    step(); drv0(0, 1, 12'h020, 4'h5, 32'hAABBCCDD); shadow_wr(12'h020, 4'h5, 32'hAABBCCDD);
    step(); drv0(1, 0, 12'h020, 4'hF, 0); #1; expect_rd(0, 32'h11BB33DD);
    // read+write together behaves as a write with no response
    step(); drv0(1, 1, 12'h021, 4'hF, 32'h77); shadow_wr(12'h021, 4'hF, 32'h77); #1;
    checks++; if (mem_write !== 1'b1) begin errors++; $display("FAIL rdwr_is_write got=%b required=1", mem_write); end
    step(); drv0(1, 0, 12'h021, 4'hF, 0); #1; expect_rd(0, 32'h77);
    step(); idle(); step();
  endtask

  task automatic test_back_to_back();
    step(); drv1(0, 1, 12'h000, 4'hF, 32'hA0A0A0A0); shadow_wr(12'h000, 4'hF, 32'hA0A0A0A0);
    step(); drv1(0, 1, 12'h001, 4'hF, 32'hB1B1B1B1); shadow_wr(12'h001, 4'hF, 32'hB1B1B1B1);
    step(); drv0(1, 0, 12'h000, 4'hF, 0); drv1(1, 0, 12'h001, 4'hF, 0);
    for (int i = 0; i < 6; i++) begin
      logic g;
      if (i > 0) step();
      #1;
      g = i[0];
      checks++;
      if ({m0_waitrequest, m1_waitrequest} !== {g, ~g} || mem_address !== {11'h0, g}) begin
        errors++; $display("FAIL rr_grant i=%0d got wait=%b addr=%h required wait=%b addr=%h", i, {m0_waitrequest, m1_waitrequest}, mem_address, {g, ~g}, {11'h0, g});
      end
      expect_rd(g, ref_mem[{11'h0, g}]);
    end
    step(); idle(); step();
  endtask

  task automatic test_read_during_write();
    step(); drv0(1, 0, 12'h030, 4'hF, 0); #1; expect_rd(0, 32'h0);
    step(); drv0(0, 0, 0, 0, 0); drv1(0, 1, 12'h030, 4'hF, 32'h55); shadow_wr(12'h030, 4'hF, 32'h55); #1;
    checks++; if (m1_waitrequest !== 1'b0) begin errors++; $display("FAIL rdw_wait1 got=%b required=0", m1_waitrequest); end
    step(); idle(); step(); drv0(1, 0, 12'h030, 4'hF, 0); #1; expect_rd(0, 32'h55);
    step(); idle(); step();
  endtask

  task automatic test_reset_req();
    step(); drv1(1, 0, 12'h020, 4'hF, 0); #1; expect_rd(1, ref_mem[12'h020]);
    step(); reset_req = 1; drv0(1, 0, 12'h010, 4'hF, 0); drv1(1, 0, 12'h001, 4'hF, 0);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step();
      #1;
      checks++;
      if ({m0_waitrequest, m1_waitrequest, mem_clken, mem_chipselect} !== 4'b1100) begin
        errors++; $display("FAIL rreq_block i=%0d got wait=%b clken=%b cs=%b required 11/0/0", i, {m0_waitrequest, m1_waitrequest}, mem_clken, mem_chipselect);
      end
    end
    step(); reset_req = 0; #1;
    checks++; if ({m0_waitrequest, m1_waitrequest} !== 2'b01) begin errors++; $display("FAIL rreq_release got=%b required=01", {m0_waitrequest, m1_waitrequest}); end
    expect_rd(0, ref_mem[12'h010]);
    step(); #1; expect_rd(1, ref_mem[12'h001]);
    step(); idle(); step();
  endtask

  task automatic test_sync_reset();
    step(); drv0(1, 0, 12'h010, 4'hF, 0); #1;
    checks++; if (m0_waitrequest !== 1'b0) begin errors++; $display("FAIL srst_acc got=%b required=0", m0_waitrequest); end
    step(); idle(); reset = 1; #1;
    checks++; if (m0_readdatavalid !== 1'b0) begin errors++; $display("FAIL srst_drop got=%b required=0", m0_readdatavalid); end
    step(); reset = 0; #1;
    checks++; if (m0_readdatavalid !== 1'b0) begin errors++; $display("FAIL srst_after got=%b required=0", m0_readdatavalid); end
    step(); drv0(1, 0, 12'h000, 4'hF, 0); drv1(1, 0, 12'h001, 4'hF, 0); #1;
    checks++; if ({m0_waitrequest, m1_waitrequest} !== 2'b01) begin errors++; $display("FAIL srst_first_grant got=%b required=01", {m0_waitrequest, m1_waitrequest}); end
    expect_rd(0, ref_mem[12'h000]);
    step(); idle(); step(); step();
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin ram[i] = 0; ref_mem[i] = 0; end
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_back_to_back();
    test_read_during_write();
    test_reset_req();
    test_sync_reset();
    step(); step();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL sb_drain left=%0d required=0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    errors++;
    $display("FAIL timeout");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end
endmodule
